// File: rtl/ccip_router_pkg.sv
// Shared types for the CCI-P response router: unit IDs, query-state codes and
// the mapping from a committed query state to the operator unit it drives.
package ccip_router_pkg;

    typedef enum logic [1:0] {
        UNIT_SCAN = 2'd0,
        UNIT_JOIN = 2'd1,
        UNIT_AGG  = 2'd2,
        UNIT_NONE = 2'd3
    } t_unit_id;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } t_switch_state;

    localparam logic [2:0] QS_SCAN = 3'd0;
    localparam logic [2:0] QS_JOIN = 3'd1;
    localparam logic [2:0] QS_AGG  = 3'd2;
    localparam logic [2:0] QS_DONE = 3'd5;

    // States with no operator unit behind them have nothing to drain.
    function automatic t_unit_id state_to_unit(input logic [2:0] qs);
        case (qs)
            QS_SCAN: return UNIT_SCAN;
            QS_JOIN: return UNIT_JOIN;
            QS_AGG:  return UNIT_AGG;
            default: return UNIT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/outstanding_ctr.sv
// Up/down counter of in-flight requests; saturates at both zero and all-ones.
module outstanding_ctr #(
    parameter int CNT_W = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] count;

    // Simultaneous issue and completion cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != '1) count <= count + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ccip_rx_router.sv
// Routes CCI-P read responses and write acks to scan/join/agg by mdata unit tag,
// and gates CSR operator switches on the outgoing unit draining. RX_ROUTER_STATS_EN adds stat counters.
module ccip_rx_router
    import ccip_router_pkg::*;
#(
    parameter int MDATA_W      = 16,
    parameter int UNIT_TAG_LSB = 14,
    parameter int CNT_W        = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_operator,
    input  logic [2:0]         req_state,
    input  logic               c0_req_fire,
    input  logic [1:0]         c0_req_unit,
    input  logic               c1_req_fire,
    input  logic [1:0]         c1_req_unit,
    input  logic               c0_rsp_valid,
    input  logic [MDATA_W-1:0] c0_rsp_mdata,
    input  logic [511:0]       c0_rsp_data,
    input  logic               c1_rsp_valid,
    input  logic [MDATA_W-1:0] c1_rsp_mdata,
    output logic [2:0]         unit_c0_valid,
    output logic [MDATA_W-1:0] unit_c0_mdata,
    output logic [511:0]       unit_c0_data,
    output logic [2:0]         unit_c1_ack,
    output logic [2:0]         active_state,
    output logic               switch_busy,
    output logic [2:0]         unit_idle
`ifdef RX_ROUTER_STATS_EN
    ,
    output logic [31:0]        stat_stray,
    output logic [31:0]        stat_drain_cycles
`endif
);

    logic [1:0]    c0_rsp_unit;
    logic [1:0]    c1_rsp_unit;
    logic [2:0]    c0_inc, c0_dec, c1_inc, c1_dec;
    logic [2:0]    c0_zero, c1_zero;
    t_switch_state state_q, state_d;
    logic [2:0]    pend_state;
    logic          drain_done;

    assign c0_rsp_unit = c0_rsp_mdata[UNIT_TAG_LSB +: 2];
    assign c1_rsp_unit = c1_rsp_mdata[UNIT_TAG_LSB +: 2];

    // Tag 3 matches no unit, so invalid responses neither route nor decrement.
    always_comb begin
        c0_inc = '0;
        c0_dec = '0;
        c1_inc = '0;
        c1_dec = '0;
        for (int u = 0; u < 3; u++) begin
            c0_inc[u] = c0_req_fire  && (c0_req_unit == 2'(u));
            c1_inc[u] = c1_req_fire  && (c1_req_unit == 2'(u));
            c0_dec[u] = c0_rsp_valid && (c0_rsp_unit == 2'(u));
            c1_dec[u] = c1_rsp_valid && (c1_rsp_unit == 2'(u));
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_ctr
        outstanding_ctr #(.CNT_W(CNT_W)) u_c0_ctr (
            .clk  (clk),
            .reset(reset),
            .inc  (c0_inc[g]),
            .dec  (c0_dec[g]),
            .zero (c0_zero[g])
        );
        outstanding_ctr #(.CNT_W(CNT_W)) u_c1_ctr (
            .clk  (clk),
            .reset(reset),
            .inc  (c1_inc[g]),
            .dec  (c1_dec[g]),
            .zero (c1_zero[g])
        );
    end

    assign unit_idle = c0_zero & c1_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            unit_c0_valid <= '0;
            unit_c1_ack   <= '0;
            unit_c0_mdata <= '0;
            unit_c0_data  <= '0;
        end else begin
            unit_c0_valid <= c0_dec;
            unit_c1_ack   <= c1_dec;
            if (c0_rsp_valid) begin
                unit_c0_mdata <= c0_rsp_mdata;
                unit_c0_data  <= c0_rsp_data;
            end
        end
    end

    always_comb begin
        drain_done = 1'b1;
        case (state_to_unit(active_state))
            UNIT_SCAN: drain_done = unit_idle[0];
            UNIT_JOIN: drain_done = unit_idle[1];
            UNIT_AGG:  drain_done = unit_idle[2];
            default:   drain_done = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (new_operator && (req_state != active_state)) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // A CSR write landing on the commit cycle itself is the latest request and wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACTIVE;
            active_state <= QS_SCAN;
            pend_state   <= QS_SCAN;
        end else begin
            state_q <= state_d;
            if (new_operator) pend_state <= req_state;
            if (state_q == ST_COMMIT) active_state <= new_operator ? req_state : pend_state;
        end
    end

    assign switch_busy = (state_q == ST_DRAIN);

`ifdef RX_ROUTER_STATS_EN
    logic [3:0] stray_events;

    // A stray is a dropped tag-3 response or a completion with nothing outstanding.
    always_comb begin
        stray_events = '0;
        if (c0_rsp_valid && (c0_rsp_unit == 2'd3)) stray_events = stray_events + 4'd1;
        if (c1_rsp_valid && (c1_rsp_unit == 2'd3)) stray_events = stray_events + 4'd1;
        for (int u = 0; u < 3; u++) begin
            if (c0_dec[u] && !c0_inc[u] && c0_zero[u]) stray_events = stray_events + 4'd1;
            if (c1_dec[u] && !c1_inc[u] && c1_zero[u]) stray_events = stray_events + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_stray        <= '0;
            stat_drain_cycles <= '0;
        end else begin
            if (stat_stray > (32'hFFFF_FFFF - 32'(stray_events))) stat_stray <= '1;
            else stat_stray <= stat_stray + 32'(stray_events);
            if ((state_q == ST_DRAIN) && (stat_drain_cycles != '1))
                stat_drain_cycles <= stat_drain_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ccip_rx_router.sv
// Self-checking bench for ccip_rx_router: directed scenarios plus randomized traffic
// against a behavioural model of routing, in-flight counts and the operator switch.
module tb_ccip_rx_router;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         new_operator = 1'b0;
    logic [2:0]   req_state = '0;
    logic         c0_req_fire = 1'b0;
    logic [1:0]   c0_req_unit = '0;
    logic         c1_req_fire = 1'b0;
    logic [1:0]   c1_req_unit = '0;
    logic         c0_rsp_valid = 1'b0;
    logic [15:0]  c0_rsp_mdata = '0;
    logic [511:0] c0_rsp_data = '0;
    logic         c1_rsp_valid = 1'b0;
    logic [15:0]  c1_rsp_mdata = '0;
    logic [2:0]   unit_c0_valid;
    logic [15:0]  unit_c0_mdata;
    logic [511:0] unit_c0_data;
    logic [2:0]   unit_c1_ack;
    logic [2:0]   active_state;
    logic         switch_busy;
    logic [2:0]   unit_idle;
`ifdef RX_ROUTER_STATS_EN
    logic [31:0]  stat_stray;
    logic [31:0]  stat_drain_cycles;
`endif

    always #5 clk = ~clk;

    ccip_rx_router dut (
        .clk          (clk),
        .reset        (reset),
        .new_operator (new_operator),
        .req_state    (req_state),
        .c0_req_fire  (c0_req_fire),
        .c0_req_unit  (c0_req_unit),
        .c1_req_fire  (c1_req_fire),
        .c1_req_unit  (c1_req_unit),
        .c0_rsp_valid (c0_rsp_valid),
        .c0_rsp_mdata (c0_rsp_mdata),
        .c0_rsp_data  (c0_rsp_data),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_mdata (c1_rsp_mdata),
        .unit_c0_valid(unit_c0_valid),
        .unit_c0_mdata(unit_c0_mdata),
        .unit_c0_data (unit_c0_data),
        .unit_c1_ack  (unit_c1_ack),
        .active_state (active_state),
        .switch_busy  (switch_busy),
        .unit_idle    (unit_idle)
`ifdef RX_ROUTER_STATS_EN
        ,
        .stat_stray       (stat_stray),
        .stat_drain_cycles(stat_drain_cycles)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: in-flight counts as plain integers, switch progress as a phase number.
    int           m_c0[3];
    int           m_c1[3];
    logic [2:0]   m_c0_valid, m_c1_ack, m_active, m_pend;
    logic [15:0]  m_mdata;
    logic [511:0] m_data;
    int           m_phase;
    longint       m_stray, m_drain;

    logic [12:0] dut_status;
    assign dut_status = {unit_c0_valid, unit_c1_ack, active_state, switch_busy, unit_idle};

    function automatic logic [12:0] exp_status();
        logic [2:0] idle;
        for (int u = 0; u < 3; u++) idle[u] = (m_c0[u] == 0) && (m_c1[u] == 0);
        return {m_c0_valid, m_c1_ack, m_active, (m_phase == 1), idle};
    endfunction

    task automatic model_edge();
        int u0, u1, du, n, inc, dec;
        bit idle;
        if (reset) begin
            for (int u = 0; u < 3; u++) begin m_c0[u] = 0; m_c1[u] = 0; end
            m_c0_valid = '0; m_c1_ack = '0; m_active = '0; m_pend = '0;
            m_mdata = '0; m_data = '0; m_phase = 0; m_stray = 0; m_drain = 0;
            return;
        end
        u0 = int'(c0_rsp_mdata[15:14]);
        u1 = int'(c1_rsp_mdata[15:14]);
        m_c0_valid = '0;
        m_c1_ack = '0;
        if (c0_rsp_valid) begin
            m_mdata = c0_rsp_mdata;
            m_data = c0_rsp_data;
            if (u0 < 3) m_c0_valid[u0] = 1'b1; else m_stray++;
        end
        if (c1_rsp_valid) begin
            if (u1 < 3) m_c1_ack[u1] = 1'b1; else m_stray++;
        end
        du = (m_active < 3) ? int'(m_active) : 3;
        idle = (du == 3) || (m_c0[du] == 0 && m_c1[du] == 0);
        if (m_phase == 1) m_drain++;
        case (m_phase)
            0: if (new_operator && req_state != m_active) m_phase = 1;
            1: if (idle) m_phase = 2;
            default: begin
                m_active = new_operator ? req_state : m_pend;
                m_phase = 0;
            end
        endcase
        if (new_operator) m_pend = req_state;
        for (int u = 0; u < 3; u++) begin
            inc = (c0_req_fire && c0_req_unit == u) ? 1 : 0;
            dec = (c0_rsp_valid && u0 == u) ? 1 : 0;
            if (dec == 1 && inc == 0 && m_c0[u] == 0) m_stray++;
            n = m_c0[u] + inc - dec;
            m_c0[u] = (n < 0) ? 0 : (n > 511) ? 511 : n;
            inc = (c1_req_fire && c1_req_unit == u) ? 1 : 0;
            dec = (c1_rsp_valid && u1 == u) ? 1 : 0;
            if (dec == 1 && inc == 0 && m_c1[u] == 0) m_stray++;
            n = m_c1[u] + inc - dec;
            m_c1[u] = (n < 0) ? 0 : (n > 511) ? 511 : n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        reset = 1'b0; new_operator = 1'b0; req_state = '0;
        c0_req_fire = 1'b0; c0_req_unit = '0; c1_req_fire = 1'b0; c1_req_unit = '0;
        c0_rsp_valid = 1'b0; c0_rsp_mdata = '0; c0_rsp_data = '0;
        c1_rsp_valid = 1'b0; c1_rsp_mdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        quiet_inputs();
        compared++;
        if (dut_status !== 13'b000_000_000_0_111) begin
            mismatched++;
            $display("[TB] FAIL reset_status actual=%b expected=%b", dut_status, 13'b000_000_000_0_111);
        end
        compared++;
        if ({unit_c0_mdata, unit_c0_data} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data actual mdata=%h expected 0", unit_c0_mdata);
        end
    endtask

    task automatic test_scan_reads();
        c0_req_fire = 1'b1;
        c0_req_unit = 2'd0;
        repeat (4) tick();
        c0_req_fire = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c0_rsp_valid = 1'b1;
            c0_rsp_mdata = 16'h0003 + 16'(i);
            c0_rsp_data = {16{$urandom()}};
            tick();
            compared++;
            if (dut_status !== exp_status()) begin
                mismatched++;
                $display("[TB] FAIL scan_rsp%0d status actual=%b expected=%b", i, dut_status, exp_status());
            end
            compared++;
            if ({unit_c0_mdata, unit_c0_data} !== {m_mdata, m_data}) begin
                mismatched++;
                $display("[TB] FAIL scan_data%0d actual=%h/%h expected=%h/%h", i, unit_c0_mdata, unit_c0_data, m_mdata, m_data);
            end
            compared++;
            if (unit_c0_valid !== 3'b001 || unit_idle[0] !== (i == 3)) begin
                mismatched++;
                $display("[TB] FAIL scan_valid_idle%0d actual valid=%b idle0=%b expected valid=001 idle0=%0d", i, unit_c0_valid, unit_idle[0], (i == 3));
            end
        end
        quiet_inputs();
        tick();
        compared++;
        if (dut_status !== exp_status()) begin
            mismatched++;
            $display("[TB] FAIL scan_after status actual=%b expected=%b", dut_status, exp_status());
        end
    endtask

    task automatic test_simultaneous();
        c0_req_fire = 1'b1;
        c0_req_unit = 2'd1;
        repeat (3) tick();
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'h4010;
        c0_rsp_data = {16{$urandom()}};
        tick();
        c0_req_fire = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c0_rsp_mdata = 16'h4020 + 16'(i);
            tick();
            compared++;
            if (dut_status !== exp_status() || unit_idle[1] !== (i == 2)) begin
                mismatched++;
                $display("[TB] FAIL simul_rsp%0d status actual=%b expected=%b", i, dut_status, exp_status());
            end
        end
        quiet_inputs();
        tick();
    endtask

    task automatic test_invalid_tag();
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'hC005;
        c0_rsp_data = {16{$urandom()}};
        tick();
        quiet_inputs();
        compared++;
        if (unit_c0_valid !== 3'b000 || dut_status !== exp_status()) begin
            mismatched++;
            $display("[TB] FAIL invalid_tag actual=%b expected=%b", dut_status, exp_status());
        end
`ifdef RX_ROUTER_STATS_EN
        compared++;
        if (stat_stray !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL invalid_stray actual=%0d expected=1", stat_stray);
        end
`endif
        tick();
    endtask

    task automatic test_double_switch();
        c0_req_fire = 1'b1;
        c0_req_unit = 2'd0;
        tick();
        quiet_inputs();
        new_operator = 1'b1;
        req_state = 3'd1;
        tick();
        quiet_inputs();
        tick();
        compared++;
        if (switch_busy !== 1'b1 || active_state !== 3'd0 || dut_status !== exp_status()) begin
            mismatched++;
            $display("[TB] FAIL dbl_drain actual=%b expected=%b", dut_status, exp_status());
        end
        new_operator = 1'b1;
        req_state = 3'd2;
        tick();
        quiet_inputs();
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'h0001;
        tick();
        quiet_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (dut_status !== exp_status()) begin
                mismatched++;
                $display("[TB] FAIL dbl_step%0d actual=%b expected=%b", i, dut_status, exp_status());
            end
        end
        compared++;
        if (active_state !== 3'd2 || switch_busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dbl_final actual state=%0d busy=%b expected state=2 busy=0", active_state, switch_busy);
        end
    endtask

    task automatic test_reset_mid_drain();
        c0_req_fire = 1'b1;
        c0_req_unit = 2'd2;
        tick();
        quiet_inputs();
        new_operator = 1'b1;
        req_state = 3'd0;
        tick();
        quiet_inputs();
        compared++;
        if (switch_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rst_drain_busy actual=%b expected=1", switch_busy);
        end
        reset = 1'b1;
        tick();
        quiet_inputs();
        compared++;
        if (active_state !== 3'd0 || switch_busy !== 1'b0 || unit_idle !== 3'b111) begin
            mismatched++;
            $display("[TB] FAIL rst_drain_state actual state=%0d busy=%b idle=%b expected 0/0/111", active_state, switch_busy, unit_idle);
        end
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = 16'h8007;
        tick();
        quiet_inputs();
        compared++;
        if (unit_c0_valid !== 3'b100 || unit_idle !== 3'b111 || dut_status !== exp_status()) begin
            mismatched++;
            $display("[TB] FAIL rst_late_rsp actual=%b expected=%b", dut_status, exp_status());
        end
    endtask

    task automatic test_drain_switch();
        bit done;
        c1_req_fire = 1'b1;
        c1_req_unit = 2'd0;
        repeat (2) tick();
        quiet_inputs();
        new_operator = 1'b1;
        req_state = 3'd1;
        tick();
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (switch_busy !== 1'b1 || active_state !== 3'd0 || dut_status !== exp_status()) begin
                mismatched++;
                $display("[TB] FAIL drain_wait%0d actual=%b expected=%b", i, dut_status, exp_status());
            end
        end
        for (int i = 0; i < 2; i++) begin
            c1_rsp_valid = 1'b1;
            c1_rsp_mdata = 16'h0100 + 16'(i);
            tick();
            compared++;
            if (unit_c1_ack !== 3'b001 || dut_status !== exp_status()) begin
                mismatched++;
                $display("[TB] FAIL drain_ack%0d actual=%b expected=%b", i, dut_status, exp_status());
            end
        end
        quiet_inputs();
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            compared++;
            if (dut_status !== exp_status()) begin
                mismatched++;
                $display("[TB] FAIL drain_commit%0d actual=%b expected=%b", i, dut_status, exp_status());
            end
            if (active_state === 3'd1) done = 1'b1;
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout actual state=%0d expected=1", active_state);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(99) == 0);
            new_operator = ($urandom_range(15) == 0);
            req_state = 3'($urandom_range(7));
            c0_req_fire = $urandom_range(1) == 1;
            c0_req_unit = 2'($urandom_range(3));
            c1_req_fire = $urandom_range(1) == 1;
            c1_req_unit = 2'($urandom_range(3));
            c0_rsp_valid = $urandom_range(1) == 1;
            c0_rsp_mdata = 16'($urandom());
            c0_rsp_data = {16{$urandom()}};
            c1_rsp_valid = $urandom_range(1) == 1;
            c1_rsp_mdata = 16'($urandom());
            tick();
            compared++;
            if (dut_status !== exp_status()) begin
                mismatched++;
                $display("[TB] FAIL rand%0d status actual=%b expected=%b", i, dut_status, exp_status());
            end
            compared++;
            if ({unit_c0_mdata, unit_c0_data} !== {m_mdata, m_data}) begin
                mismatched++;
                $display("[TB] FAIL rand%0d data actual=%h expected=%h", i, unit_c0_mdata, m_mdata);
            end
`ifdef RX_ROUTER_STATS_EN
            compared++;
            if (stat_stray !== 32'(m_stray) || stat_drain_cycles !== 32'(m_drain)) begin
                mismatched++;
                $display("[TB] FAIL rand%0d stats actual=%0d/%0d expected=%0d/%0d", i, stat_stray, stat_drain_cycles, m_stray, m_drain);
            end
`endif
        end
        quiet_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_scan_reads();
        test_simultaneous();
        test_invalid_tag();
        test_double_switch();
        test_reset_mid_drain();
        test_drain_switch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
